vga_scan_gen: RTL and testbench

Generates 640x480@60 VGA scan timing and pixel addresses for the frame buffer, and turns the returned pixel into VGA outputs. It sits between `vmem` and the VGA pins in `top`. Each cycle it drives `h_addr`/`v_addr` into `vmem`, takes the combinational `vga_data` back, and registers sync, blank and RGB. All VGA outputs are cycle-aligned.

---
 rtl/vga_pkg.sv | 12 +
 rtl/mod_counter.sv | 16 +
 rtl/vga_scan_gen.sv | 58 +++++
 tb/tb_vga_scan_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants shared by the scan generator.
package vga_pkg;
  localparam int CNT_W = 10;
  localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_ACTIVE = 480, V_FP = 10, V_SYNC = 2, V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: enabled 0..MAX-1 wrap counter; wrap flags the enabled terminal step.
module mod_counter #(
  parameter int MAX = vga_pkg::H_TOTAL,
  parameter int W = vga_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = en && (cnt == W'(MAX - 1));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA scan counters, frame-buffer addressing and registered sync/blank/RGB.
module vga_scan_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pix_en,
  input  logic [23:0] vga_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [9:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap, active0;
  mod_counter #(.MAX(H_TOTAL), .W(10)) u_h (
    .clk(clk), .resetn(resetn), .en(pix_en), .cnt(h_cnt), .wrap(h_wrap)
  );
  // the vertical counter steps only on the horizontal wrap
  mod_counter #(.MAX(V_TOTAL), .W(10)) u_v (
    .clk(clk), .resetn(resetn), .en(h_wrap), .cnt(v_cnt), .wrap(v_wrap)
  );
  assign active0 = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign h_addr = active0 ? h_cnt : '0;
  assign v_addr = active0 ? v_cnt : '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      valid <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hsync <= !(h_cnt >= HS0 && h_cnt <= HS1);
      vsync <= !(v_cnt >= VS0 && v_cnt <= VS1);
      valid <= active0;
      {vga_r, vga_g, vga_b} <= active0 ? vga_data : 24'h0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed checks of full-size line timing plus a shrunken-timing instance for frame behaviour.
module tb_vga_scan_gen;
  logic clk = 1'b0, resetn = 1'b0, pix_en = 1'b1;
  logic [23:0] data0, data1;
  logic [9:0] ha0, va0, ha1, va1;
  logic hs0, vs0, vl0, fs0, hs1, vs1, vl1, fs1;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  assign data0 = {ha0[7:0], va0[7:0], 8'hA5};
  assign data1 = {ha1[7:0], va1[7:0], 8'hA5};

  vga_scan_gen d0 (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .vga_data(data0),
    .h_addr(ha0), .v_addr(va0), .hsync(hs0), .vsync(vs0), .valid(vl0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .frame_start(fs0)
  );

  // small timing: 8+2+3+2 = 15 pixels/line, 6+2+2+3 = 13 lines/frame
  vga_scan_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) d1 (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .vga_data(data1),
    .h_addr(ha1), .v_addr(va1), .hsync(hs1), .vsync(vs1), .valid(vl1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1)
  );

  typedef struct {
    int at;
    logic hs, vs, vl, fs;
    logic [23:0] rgb;
    logic [9:0] ha, va;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] pk(logic hs, logic vs, logic vl, logic fs, logic [23:0] rgb,
                                     logic [9:0] ha, logic [9:0] va);
    return {hs, vs, vl, fs, rgb, ha, va};
  endfunction

  initial begin
    vec_t tbl[11];
    int cur;
    int t, h, v, fs_cnt, vs_pulses, vs_low, vl_cnt, hs_low;
    logic prev_vs;
    logic [47:0] e;
    // {edge after release, hs, vs, valid, frame_start, rgb, h_addr, v_addr}
    tbl[0]  = '{1,    1, 1, 1, 1, 24'h0000A5, 10'd1,   10'd0};
    tbl[1]  = '{2,    1, 1, 1, 0, 24'h0100A5, 10'd2,   10'd0};
    tbl[2]  = '{640,  1, 1, 1, 0, 24'h7F00A5, 10'd0,   10'd0};
    tbl[3]  = '{641,  1, 1, 0, 0, 24'h000000, 10'd0,   10'd0};
    tbl[4]  = '{656,  1, 1, 0, 0, 24'h000000, 10'd0,   10'd0};
    tbl[5]  = '{657,  0, 1, 0, 0, 24'h000000, 10'd0,   10'd0};
    tbl[6]  = '{752,  0, 1, 0, 0, 24'h000000, 10'd0,   10'd0};
    tbl[7]  = '{753,  1, 1, 0, 0, 24'h000000, 10'd0,   10'd0};
    tbl[8]  = '{800,  1, 1, 0, 0, 24'h000000, 10'd0,   10'd1};
    tbl[9]  = '{801,  1, 1, 1, 0, 24'h0001A5, 10'd1,   10'd1};
    tbl[10] = '{2405, 1, 1, 1, 0, 24'h0403A5, 10'd5,   10'd3};

    repeat (3) step();
    chk("reset_big", pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
        pk(1, 1, 0, 0, 24'h0, 10'd0, 10'd0));
    chk("reset_small", pk(hs1, vs1, vl1, fs1, {r1, g1, b1}, ha1, va1),
        pk(1, 1, 0, 0, 24'h0, 10'd0, 10'd0));

    resetn = 1'b1;
    cur = 0;
    foreach (tbl[i]) begin
      while (cur < tbl[i].at) begin
        step();
        cur++;
      end
      chk($sformatf("vec%0d_edge%0d", i, tbl[i].at),
          pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
          pk(tbl[i].hs, tbl[i].vs, tbl[i].vl, tbl[i].fs, tbl[i].rgb, tbl[i].ha, tbl[i].va));
    end

    // line 3, h_cnt 5 -> 300; outputs show (299,3)
    repeat (295) step();
    chk("pre_stall", pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
        pk(1, 1, 1, 0, 24'h2B03A5, 10'd300, 10'd3));
    pix_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall%0d", k), pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
          pk(1, 1, 1, 0, 24'h2B03A5, 10'd300, 10'd3));
    end
    pix_en = 1'b1;
    step();
    chk("resume", pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
        pk(1, 1, 1, 0, 24'h2C03A5, 10'd301, 10'd3));
    repeat (499) step();
    chk("stretched_line_end", pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
        pk(1, 1, 0, 0, 24'h0, 10'd0, 10'd4));
    step();
    chk("next_line_start", pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
        pk(1, 1, 1, 0, 24'h0004A5, 10'd1, 10'd4));

    // mid-line asynchronous reset at (400,4)
    repeat (399) step();
    chk("pre_reset", pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
        pk(1, 1, 1, 0, 24'h8F04A5, 10'd400, 10'd4));
    #2 resetn = 1'b0;
    #1;
    chk("async_reset", pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
        pk(1, 1, 0, 0, 24'h0, 10'd0, 10'd0));
    repeat (3) step();
    chk("reset_held", pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
        pk(1, 1, 0, 0, 24'h0, 10'd0, 10'd0));
    resetn = 1'b1;

    // two full frames of the small instance against a time-based model
    fs_cnt = 0; vs_pulses = 0; vs_low = 0; vl_cnt = 0; hs_low = 0;
    prev_vs = 1'b1;
    for (int n = 1; n <= 2 * 195; n++) begin
      step();
      if (n == 1)
        chk("restart_big", pk(hs0, vs0, vl0, fs0, {r0, g0, b0}, ha0, va0),
            pk(1, 1, 1, 1, 24'h0000A5, 10'd1, 10'd0));
      t = n - 1;
      h = t % 15;
      v = (t / 15) % 13;
      e = pk(!(h >= 10 && h <= 12), !(v >= 8 && v <= 9), h < 8 && v < 6, h == 0 && v == 0,
             (h < 8 && v < 6) ? {8'(h), 8'(v), 8'hA5} : 24'h0, 10'd0, 10'd0);
      chk($sformatf("small_t%0d", t), pk(hs1, vs1, vl1, fs1, {r1, g1, b1}, 10'd0, 10'd0), e);
      if (h == 7 && v == 5) chk("small_last_pixel", {40'h0, r1, g1, b1}, 64'h0705A5);
      fs_cnt += int'(fs1);
      vl_cnt += int'(vl1);
      hs_low += int'(!hs1);
      vs_low += int'(!vs1);
      if (prev_vs && !vs1) vs_pulses++;
      prev_vs = vs1;
    end
    chk("frame_starts", 64'(fs_cnt), 64'd2);
    chk("vsync_pulses", 64'(vs_pulses), 64'd2);
    chk("vsync_low_cycles", 64'(vs_low), 64'd60);
    chk("valid_cycles", 64'(vl_cnt), 64'd96);
    chk("hsync_low_cycles", 64'(hs_low), 64'd78);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
